// File: rtl/modport_fifo_pkg.sv
// Shared definitions for the modport_fifo slice.
//   DATA_W_DEF / DEPTH_DEF   : default word width and entry count
//   ADDR_W_DEF               : pointer width derived from DEPTH_DEF
//   AF_LVL_DEF / AE_LVL_DEF  : default almost-full / almost-empty thresholds
//   op_e                     : per-cycle accepted operation, encoded {write, read}
package modport_fifo_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned DEPTH_DEF  = 16;
  localparam int unsigned ADDR_W_DEF = $clog2(DEPTH_DEF);
  localparam int unsigned AF_LVL_DEF = DEPTH_DEF - 2;
  localparam int unsigned AE_LVL_DEF = 2;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10,
    OP_BOTH = 2'b11
  } op_e;

endpackage

// File: rtl/modport_fifo_mem.sv
// DEPTH x DATA_W register array for modport_fifo.
//   clk, rstn          : clock, async active-low reset (read register only)
//   wr_en/wr_addr/wr_data : synchronous write port
//   rd_en/rd_addr      : read request; rd_data loads mem[rd_addr] on the edge
//   rd_data            : registered read data, holds when rd_en is low
// The array itself is not reset.
module modport_fifo_mem
  import modport_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Same-address read and write in one cycle returns the old word,
  // which is what a full FIFO doing read+write needs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)      rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/modport_fifo.sv
// Synchronous FIFO with registered read data and occupancy flags.
//   clk, rstn    : clock, async active-low reset
//   i_wren       : write request; i_wrdata captured when accepted
//   i_rden       : read request; o_rddata updates one edge later-visible
//   o_rddata     : registered read data, holds without an accepted read
//   o_empty      : occupancy == 0          o_alm_empty : occupancy <= AE_LVL
//   o_full       : occupancy == DEPTH      o_alm_full  : occupancy >= AF_LVL
module modport_fifo
  import modport_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned AF_LVL = DEPTH - 2,
  parameter int unsigned AE_LVL = AE_LVL_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_wren,
  input  logic              i_rden,
  input  logic [DATA_W-1:0] i_wrdata,
  output logic [DATA_W-1:0] o_rddata,
  output logic              o_empty,
  output logic              o_alm_empty,
  output logic              o_full,
  output logic              o_alm_full
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W  = ADDR_W + 1;

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              rd_acc;
  logic              wr_acc;
  op_e               op;

  // A read frees a slot in the same edge, so a full FIFO may still accept a write.
  always_comb begin
    rd_acc = i_rden && !o_empty;
    wr_acc = i_wren && (!o_full || rd_acc);
    op     = op_e'({wr_acc, rd_acc});
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      case (op)
        OP_WR:   count <= count + 1'b1;
        OP_RD:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    o_empty     = (count == '0);
    o_full      = (count == CNT_W'(DEPTH));
    o_alm_empty = (count <= CNT_W'(AE_LVL));
    o_alm_full  = (count >= CNT_W'(AF_LVL));
  end

  modport_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (i_wrdata),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr),
    .rd_data (o_rddata)
  );

endmodule

// File: tb/tb_modport_fifo.sv
module tb_modport_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rstn;
  logic       i_wren;
  logic       i_rden;
  logic [7:0] i_wrdata;
  logic [7:0] o_rddata;
  logic       o_empty;
  logic       o_alm_empty;
  logic       o_full;
  logic       o_alm_full;

  modport_fifo #(
    .DATA_W (8),
    .DEPTH  (16),
    .AF_LVL (14),
    .AE_LVL (2)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .i_wren      (i_wren),
    .i_rden      (i_rden),
    .i_wrdata    (i_wrdata),
    .o_rddata    (o_rddata),
    .o_empty     (o_empty),
    .o_alm_empty (o_alm_empty),
    .o_full      (o_full),
    .o_alm_full  (o_alm_full)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard: entries queued on accepted writes, popped on accepted reads.
  logic [7:0] sb_q[$];
  logic [7:0] exp_rd;

  typedef struct {
    bit         wr;
    bit         rd;
    logic [7:0] d;
    bit         e;
    bit         ae;
    bit         f;
    bit         af;
    logic [7:0] rdata;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    int c;
    c = sb_q.size();
    chk({tag, ".rddata"},    32'(o_rddata),    32'(exp_rd));
    chk({tag, ".empty"},     32'(o_empty),     32'(c == 0));
    chk({tag, ".alm_empty"}, 32'(o_alm_empty), 32'(c <= 2));
    chk({tag, ".full"},      32'(o_full),      32'(c == DEPTH));
    chk({tag, ".alm_full"},  32'(o_alm_full),  32'(c >= 14));
  endtask

  // One clock of stimulus; the model decides acceptance from its own occupancy.
  task automatic step(input bit wr, input bit rd, input logic [7:0] d, input string tag);
    bit ra, wa;
    i_wren   = wr;
    i_rden   = rd;
    i_wrdata = d;
    @(posedge clk);
    ra = rd && (sb_q.size() != 0);
    wa = wr && ((sb_q.size() != DEPTH) || ra);
    if (ra) exp_rd = sb_q.pop_front();
    if (wa) sb_q.push_back(d);
    #1;
    i_wren = 1'b0;
    i_rden = 1'b0;
    chk_model(tag);
  endtask

  initial begin
    rstn     = 1'b0;
    i_wren   = 1'b0;
    i_rden   = 1'b0;
    i_wrdata = '0;
    exp_rd   = '0;

    // Hand-computed short sequence starting from empty
    vecs[0] = '{1, 0, 8'h11, 0, 1, 0, 0, 8'h00};
    vecs[1] = '{1, 0, 8'h22, 0, 1, 0, 0, 8'h00};
    vecs[2] = '{1, 0, 8'h33, 0, 0, 0, 0, 8'h00};
    vecs[3] = '{0, 1, 8'h00, 0, 1, 0, 0, 8'h11};
    vecs[4] = '{1, 1, 8'h44, 0, 1, 0, 0, 8'h22};
    vecs[5] = '{0, 1, 8'h00, 0, 1, 0, 0, 8'h33};
    vecs[6] = '{0, 1, 8'h00, 1, 1, 0, 0, 8'h44};
    vecs[7] = '{0, 1, 8'h00, 1, 1, 0, 0, 8'h44};
    vecs[8] = '{1, 1, 8'h55, 0, 1, 0, 0, 8'h44};
    vecs[9] = '{0, 1, 8'h00, 1, 1, 0, 0, 8'h55};

    repeat (2) @(posedge clk);
    #1;
    chk("rst.empty",     32'(o_empty),     32'd1);
    chk("rst.alm_empty", 32'(o_alm_empty), 32'd1);
    chk("rst.full",      32'(o_full),      32'd0);
    chk("rst.alm_full",  32'(o_alm_full),  32'd0);
    chk("rst.rddata",    32'(o_rddata),    32'd0);
    @(negedge clk);
    rstn = 1'b1;
    step(0, 0, 8'h00, "idle");
    step(0, 0, 8'h00, "idle2");

    for (int i = 0; i < 10; i++) begin
      step(vecs[i].wr, vecs[i].rd, vecs[i].d, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d.t_empty", i),  32'(o_empty),     32'(vecs[i].e));
      chk($sformatf("vec%0d.t_aempty", i), 32'(o_alm_empty), 32'(vecs[i].ae));
      chk($sformatf("vec%0d.t_full", i),   32'(o_full),      32'(vecs[i].f));
      chk($sformatf("vec%0d.t_afull", i),  32'(o_alm_full),  32'(vecs[i].af));
      chk($sformatf("vec%0d.t_rddata", i), 32'(o_rddata),    32'(vecs[i].rdata));
    end

    // Occupancy sweep 0->16 with ordered data, then drain in order
    for (int i = 1; i <= 16; i++) step(1, 0, 8'(i), $sformatf("fill%0d", i));
    chk("fill.full", 32'(o_full), 32'd1);
    for (int i = 1; i <= 16; i++) begin
      step(0, 1, 8'h00, $sformatf("drain%0d", i));
      chk($sformatf("drain%0d.order", i), 32'(o_rddata), 32'(i));
    end
    chk("drain.empty", 32'(o_empty), 32'd1);

    // Fill, overflow write dropped, read+write while full, drain
    for (int i = 0; i < 16; i++) step(1, 0, 8'(8'h80 + i), "ofill");
    step(1, 0, 8'hAA, "ovf");
    step(1, 1, 8'hC3, "rw_full");
    chk("rw_full.rd", 32'(o_rddata), 32'h80);
    chk("rw_full.full", 32'(o_full), 32'd1);
    for (int i = 0; i < 16; i++) step(0, 1, 8'h00, $sformatf("odrain%0d", i));
    chk("odrain.last", 32'(o_rddata), 32'hC3);

    // Read+write at empty, then at count 5
    step(1, 1, 8'h5A, "rw_empty");
    chk("rw_empty.rd_held", 32'(o_rddata), 32'hC3);
    for (int i = 0; i < 4; i++) step(1, 0, 8'(8'h60 + i), "to5");
    step(1, 1, 8'h6F, "rw_5");
    chk("rw_5.rd", 32'(o_rddata), 32'h5A);
    for (int i = 0; i < 5; i++) step(0, 1, 8'h00, $sformatf("d5_%0d", i));
    chk("d5.empty", 32'(o_empty), 32'd1);
    chk("d5.last", 32'(o_rddata), 32'h6F);

    // Wrap-around: offset pointers, then cross the DEPTH-1 -> 0 boundary
    for (int i = 0; i < 12; i++) step(1, 0, 8'(8'h20 + i), "wrapA");
    for (int i = 0; i < 12; i++) step(1, 1, 8'(8'h40 + i), "wrapB");
    for (int i = 0; i < 12; i++) step(0, 1, 8'h00, "wrapC");

    // Mid-cycle async reset with 10 entries stored
    for (int i = 0; i < 10; i++) step(1, 0, 8'(8'hE0 + i), "prerst");
    step(0, 1, 8'h00, "prerst_rd");
    chk("prerst.rd", 32'(o_rddata), 32'hE0);
    #2 rstn = 1'b0;
    #1;
    chk("arst.empty",     32'(o_empty),     32'd1);
    chk("arst.alm_empty", 32'(o_alm_empty), 32'd1);
    chk("arst.full",      32'(o_full),      32'd0);
    chk("arst.alm_full",  32'(o_alm_full),  32'd0);
    chk("arst.rddata",    32'(o_rddata),    32'd0);
    sb_q.delete();
    exp_rd = '0;
    @(negedge clk);
    rstn = 1'b1;
    step(0, 1, 8'h00, "post_rd0");
    step(0, 1, 8'h00, "post_rd1");
    chk("post.rddata0", 32'(o_rddata), 32'd0);
    step(1, 0, 8'h77, "first_wr");
    step(0, 1, 8'h00, "first_rd");
    chk("first.rd", 32'(o_rddata), 32'h77);
    step(0, 1, 8'h00, "empty_rd");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
